// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, funct3
// access codes and the alignment helper used by the IDLE error check.
package lsu_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Halfwords need an even address, words a 4-byte aligned one.
  // funct3[1:0] carries the size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) ||
           ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_load_data_formatter.sv
// Picks the addressed byte/half out of the bus read word and extends it
// to 32 bits according to funct3. Purely combinational.
module load_data_formatter
  import lsu_defs::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select followed by sign or zero extension.
  always_comb begin
    w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];
    o_data = 32'h0;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_rdata;
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LHU:  o_data = {16'h0, w_half};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: turns the ALU result into a request/grant/
// response transaction on the data bus and stalls the core meanwhile.
//
// state | meaning
// IDLE  | waiting for a load/store; errors are checked here only
// REQ   | Bus_Req_o held with stable addr/we/wdata/be until grant
// WAIT  | load granted, waiting for Bus_Rvalid_i
// DONE  | access finished (or aborted); core retires, back to IDLE
module load_store_unit
  import lsu_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Read_i,
  input  logic        Mem_Write_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Store_Data_i,
  output logic [31:0] Load_Data_o,
  output logic        Stall_o,
  output logic        Access_Error_o,
  output logic        Bus_Timeout_o,
  output logic        Bus_Req_o,
  output logic        Bus_We_o,
  output logic [31:0] Bus_Addr_o,
  output logic [31:0] Bus_Wdata_o,
  output logic [3:0]  Bus_Be_o,
  input  logic        Bus_Gnt_i,
  input  logic        Bus_Rvalid_i,
  input  logic [31:0] Bus_Rdata_i
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  lsu_state_t  r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;

  logic        w_req;
  logic        w_bad_f3;
  logic        w_error;
  logic        w_accept;
  logic        w_timeout;
  logic [7:0]  w_cnt_nxt;
  logic [3:0]  w_store_be;
  logic [31:0] w_store_wdata;
  logic [31:0] w_fmt;

  // Request decode and legality check; only meaningful in IDLE.
  always_comb begin
    w_req    = Mem_Read_i | Mem_Write_i;
    w_bad_f3 = 1'b0;
    if (Mem_Read_i)
      w_bad_f3 = (Funct3_i == 3'b011) || (Funct3_i == 3'b110) || (Funct3_i == 3'b111);
    else if (Mem_Write_i)
      w_bad_f3 = Funct3_i[2] || (Funct3_i == 3'b011);
    w_error  = (r_state == ST_IDLE) && w_req &&
               ((Mem_Read_i && Mem_Write_i) || w_bad_f3 ||
                is_misaligned(Funct3_i, Address_i[1:0]));
    w_accept = (r_state == ST_IDLE) && w_req && !w_error;
  end

  // Store lane replication and byte enables.
  always_comb begin
    w_store_be    = 4'b1111;
    w_store_wdata = Store_Data_i;
    case (Funct3_i[1:0])
      2'b00: begin
        w_store_be    = 4'b0001 << Address_i[1:0];
        w_store_wdata = {4{Store_Data_i[7:0]}};
      end
      2'b01: begin
        w_store_be    = Address_i[1] ? 4'b1100 : 4'b0011;
        w_store_wdata = {2{Store_Data_i[15:0]}};
      end
      default: begin
        w_store_be    = 4'b1111;
        w_store_wdata = Store_Data_i;
      end
    endcase
  end

  // Timeout fires on the cycle the REQ+WAIT count reaches the limit.
  always_comb begin
    w_cnt_nxt = r_cnt + 8'd1;
    w_timeout = ((r_state == ST_REQ) || (r_state == ST_WAIT)) &&
                (w_cnt_nxt == TIMEOUT_LIMIT);
    Stall_o   = w_accept || (r_state == ST_REQ) || (r_state == ST_WAIT);
  end

  load_data_formatter u_fmt (
    .i_rdata  (Bus_Rdata_i),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_data   (w_fmt)
  );

  // Transaction FSM with registered bus and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 8'h0;
      r_funct3       <= 3'b000;
      r_offset       <= 2'b00;
      Load_Data_o    <= 32'h0;
      Access_Error_o <= 1'b0;
      Bus_Timeout_o  <= 1'b0;
      Bus_Req_o      <= 1'b0;
      Bus_We_o       <= 1'b0;
      Bus_Addr_o     <= 32'h0;
      Bus_Wdata_o    <= 32'h0;
      Bus_Be_o       <= 4'h0;
    end else begin
      Access_Error_o <= 1'b0;
      Bus_Timeout_o  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_error) begin
            Access_Error_o <= 1'b1;
            Load_Data_o    <= 32'h0;
          end else if (w_accept) begin
            r_state     <= ST_REQ;
            r_cnt       <= 8'h0;
            r_funct3    <= Funct3_i;
            r_offset    <= Address_i[1:0];
            Bus_Req_o   <= 1'b1;
            Bus_We_o    <= Mem_Write_i;
            Bus_Addr_o  <= {Address_i[31:2], 2'b00};
            Bus_Wdata_o <= Mem_Write_i ? w_store_wdata : 32'h0;
            Bus_Be_o    <= Mem_Write_i ? w_store_be : 4'b1111;
          end
        end
        ST_REQ: begin
          r_cnt <= w_cnt_nxt;
          if (w_timeout) begin
            Bus_Timeout_o <= 1'b1;
            Bus_Req_o     <= 1'b0;
            Load_Data_o   <= 32'h0;
            r_state       <= ST_DONE;
          end else if (Bus_Gnt_i) begin
            Bus_Req_o <= 1'b0;
            r_state   <= Bus_We_o ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (w_timeout) begin
            Bus_Timeout_o <= 1'b1;
            Load_Data_o   <= 32'h0;
            r_state       <= ST_DONE;
          end else if (Bus_Rvalid_i) begin
            Load_Data_o <= w_fmt;
            r_state     <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one default-timeout instance and one
// built with TIMEOUT_CYCLES=4, both driven from the same stimulus.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, sdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  logic [31:0] ld, baddr, bwdata;
  logic        stall, aerr, tout, breq, bwe;
  logic [3:0]  bbe;
  logic [31:0] ld_t, baddr_t, bwdata_t;
  logic        stall_t, aerr_t, tout_t, breq_t, bwe_t;
  logic [3:0]  bbe_t;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit u_dut (
    .clk(clk), .reset(reset), .Mem_Read_i(mem_read), .Mem_Write_i(mem_write),
    .Funct3_i(funct3), .Address_i(addr), .Store_Data_i(sdata),
    .Load_Data_o(ld), .Stall_o(stall), .Access_Error_o(aerr), .Bus_Timeout_o(tout),
    .Bus_Req_o(breq), .Bus_We_o(bwe), .Bus_Addr_o(baddr), .Bus_Wdata_o(bwdata),
    .Bus_Be_o(bbe), .Bus_Gnt_i(gnt), .Bus_Rvalid_i(rvalid), .Bus_Rdata_i(rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk(clk), .reset(reset), .Mem_Read_i(mem_read), .Mem_Write_i(mem_write),
    .Funct3_i(funct3), .Address_i(addr), .Store_Data_i(sdata),
    .Load_Data_o(ld_t), .Stall_o(stall_t), .Access_Error_o(aerr_t), .Bus_Timeout_o(tout_t),
    .Bus_Req_o(breq_t), .Bus_We_o(bwe_t), .Bus_Addr_o(baddr_t), .Bus_Wdata_o(bwdata_t),
    .Bus_Be_o(bbe_t), .Bus_Gnt_i(gnt), .Bus_Rvalid_i(rvalid), .Bus_Rdata_i(rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = 32'h0;
    sdata = 32'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    n_checks++; if (ld !== 32'h0) begin n_errors++; $display("FAIL rst_ld actual=%h expected=%h", ld, 32'h0); end
    n_checks++; if (breq !== 1'b0 || bwe !== 1'b0) begin n_errors++; $display("FAIL rst_req_we actual=%b%b expected=00", breq, bwe); end
    n_checks++; if (baddr !== 32'h0 || bwdata !== 32'h0 || bbe !== 4'h0) begin n_errors++; $display("FAIL rst_bus actual=%h/%h/%h expected=0/0/0", baddr, bwdata, bbe); end
    n_checks++; if (aerr !== 1'b0 || tout !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL rst_flags actual=%b%b%b expected=000", aerr, tout, stall); end
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL rst_stall_decode actual=%b expected=1", stall); end
    step();
    n_checks++; if (breq !== 1'b0) begin n_errors++; $display("FAIL rst_no_req actual=%b expected=0", breq); end
    clear_inputs();
    reset = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h100; sdata = 32'hA5A5_1234;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL sw_stall_idle actual=%b expected=1", stall); end
    n_checks++; if (breq !== 1'b0) begin n_errors++; $display("FAIL sw_req_not_yet actual=%b expected=0", breq); end
    step();
    n_checks++; if (breq !== 1'b1 || bwe !== 1'b1) begin n_errors++; $display("FAIL sw_req_we actual=%b%b expected=11", breq, bwe); end
    n_checks++; if (bbe !== 4'b1111 || baddr !== 32'h100) begin n_errors++; $display("FAIL sw_be_addr actual=%b/%h expected=1111/00000100", bbe, baddr); end
    n_checks++; if (bwdata !== 32'hA5A5_1234) begin n_errors++; $display("FAIL sw_wdata actual=%h expected=a5a51234", bwdata); end
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL sw_stall_req actual=%b expected=1", stall); end
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    n_checks++; if (stall !== 1'b0 || breq !== 1'b0) begin n_errors++; $display("FAIL sw_done actual=stall%b req%b expected=stall0 req0", stall, breq); end
    step();
    mem_write = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0 || breq !== 1'b0) begin n_errors++; $display("FAIL sw_no_retrigger actual=stall%b req%b expected=stall0 req0", stall, breq); end
    step();
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp, input string name);
    mem_read = 1'b1; funct3 = f3; addr = 32'h103;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL %s_stall_idle actual=%b expected=1", name, stall); end
    step();
    n_checks++; if (breq !== 1'b1 || bwe !== 1'b0 || bbe !== 4'b1111 || baddr !== 32'h100) begin n_errors++; $display("FAIL %s_req actual=req%b we%b be%b addr%h expected=req1 we0 be1111 addr00000100", name, breq, bwe, bbe, baddr); end
    step();
    n_checks++; if (breq !== 1'b1) begin n_errors++; $display("FAIL %s_req_held actual=%b expected=1", name, breq); end
    step();
    gnt = 1'b1; rvalid = 1'b1; rdata = 32'h0000_00AA;
    step();
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    n_checks++; if (breq !== 1'b0 || stall !== 1'b1) begin n_errors++; $display("FAIL %s_wait actual=req%b stall%b expected=req0 stall1", name, breq, stall); end
    step();
    step();
    rvalid = 1'b1; rdata = 32'h80FF_0000;
    step();
    rvalid = 1'b0; rdata = 32'h0;
    n_checks++; if (ld !== exp) begin n_errors++; $display("FAIL %s_data actual=%h expected=%h", name, ld, exp); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL %s_stall_done actual=%b expected=0", name, stall); end
    mem_read = 1'b0;
    step();
  endtask

  task automatic test_store_lanes(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] exp_be, input logic [31:0] exp_wd, input string name);
    mem_write = 1'b1; funct3 = f3; addr = a; sdata = d;
    step();
    n_checks++; if (bbe !== exp_be) begin n_errors++; $display("FAIL %s_be actual=%b expected=%b", name, bbe, exp_be); end
    n_checks++; if (bwdata !== exp_wd || baddr !== {a[31:2], 2'b00}) begin n_errors++; $display("FAIL %s_wdata_addr actual=%h/%h expected=%h/%h", name, bwdata, baddr, exp_wd, {a[31:2], 2'b00}); end
    gnt = 1'b1;
    step();
    gnt = 1'b0; mem_write = 1'b0;
    step();
  endtask

  task automatic test_access_error(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a, input string name);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; sdata = 32'h1234_5678;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL %s_stall actual=%b expected=0", name, stall); end
    step();
    clear_inputs();
    n_checks++; if (aerr !== 1'b1 || breq !== 1'b0 || ld !== 32'h0) begin n_errors++; $display("FAIL %s_pulse actual=err%b req%b ld%h expected=err1 req0 ld00000000", name, aerr, breq, ld); end
    step();
    n_checks++; if (aerr !== 1'b0 || breq !== 1'b0) begin n_errors++; $display("FAIL %s_end actual=err%b req%b expected=err0 req0", name, aerr, breq); end
  endtask

  task automatic test_load_word_latency();
    do_reset();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
    step();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    n_checks++; if (stall !== 1'b1 || breq !== 1'b0) begin n_errors++; $display("FAIL lw_wait actual=stall%b req%b expected=stall1 req0", stall, breq); end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    rvalid = 1'b0; rdata = 32'h0;
    n_checks++; if (ld !== 32'hDEAD_BEEF || ld_t !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL lw_data actual=%h/%h expected=deadbeef", ld, ld_t); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL lw_stall_done actual=%b expected=0", stall); end
    mem_read = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40;
    step();
    step();
    step();
    step();
    n_checks++; if (breq_t !== 1'b1 || tout_t !== 1'b0) begin n_errors++; $display("FAIL to_req4 actual=req%b tout%b expected=req1 tout0", breq_t, tout_t); end
    step();
    n_checks++; if (tout_t !== 1'b1 || breq_t !== 1'b0) begin n_errors++; $display("FAIL to_pulse actual=tout%b req%b expected=tout1 req0", tout_t, breq_t); end
    n_checks++; if (ld_t !== 32'h0 || stall_t !== 1'b0) begin n_errors++; $display("FAIL to_done actual=ld%h stall%b expected=ld00000000 stall0", ld_t, stall_t); end
    mem_read = 1'b0;
    step();
    n_checks++; if (tout_t !== 1'b0 || stall_t !== 1'b0 || breq_t !== 1'b0) begin n_errors++; $display("FAIL to_idle actual=tout%b stall%b req%b expected=000", tout_t, stall_t, breq_t); end
  endtask

  task automatic test_timeout_wins();
    do_reset();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h80;
    step();
    step();
    step();
    step();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    n_checks++; if (tout_t !== 1'b1 || stall_t !== 1'b0) begin n_errors++; $display("FAIL to_wins actual=tout%b stall%b expected=tout1 stall0", tout_t, stall_t); end
    mem_read = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
    step();
    gnt = 1'b1;
    step();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1122_3344;
    step();
    rvalid = 1'b0; rdata = 32'h0;
    n_checks++; if (ld !== 32'h1122_3344) begin n_errors++; $display("FAIL rw_preload actual=%h expected=11223344", ld); end
    mem_read = 1'b0;
    step();
    mem_read = 1'b1;
    step();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL rw_in_wait actual=%b expected=1", stall); end
    reset = 1'b0; mem_read = 1'b0;
    #1;
    n_checks++; if (ld !== 32'h0 || breq !== 1'b0 || bwe !== 1'b0 || bbe !== 4'h0 || baddr !== 32'h0 || stall !== 1'b0) begin n_errors++; $display("FAIL rw_async actual=ld%h req%b we%b be%b addr%h stall%b expected=all zero", ld, breq, bwe, bbe, baddr, stall); end
    step();
    reset = 1'b1;
    step();
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    step();
    rvalid = 1'b0; rdata = 32'h0;
    step();
    n_checks++; if (ld !== 32'h0 || breq !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL rw_stray actual=ld%h req%b stall%b expected=ld00000000 req0 stall0", ld, breq, stall); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_word();
    test_load_byte(3'b000, 32'hFFFF_FF80, "lb");
    test_load_byte(3'b100, 32'h0000_0080, "lbu");
    test_store_lanes(3'b001, 32'h202, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, "sh");
    test_store_lanes(3'b000, 32'h301, 32'h1234_5677, 4'b0010, 32'h7777_7777, "sb");
    test_access_error(1'b1, 1'b0, 3'b001, 32'h201, "lh_misaligned");
    test_access_error(1'b1, 1'b1, 3'b010, 32'h000, "rd_and_wr");
    test_access_error(1'b1, 1'b0, 3'b011, 32'h000, "ld_f3_011");
    test_access_error(1'b0, 1'b1, 3'b100, 32'h000, "st_f3_100");
    test_access_error(1'b1, 1'b0, 3'b010, 32'h102, "lw_misaligned");
    test_load_word_latency();
    test_timeout();
    test_timeout_wins();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
